xtb_01: RTL and testbench



---
 rtl/xtb_01_pkg.sv | 38 +++
 rtl/xtb_01_spi_master.sv | 99 +++++++++
 rtl/xtb_01.sv | 204 ++++++++++++++++++++
 tb/tb_xtb_01.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xtb_01_pkg.sv
// Shared constants for the XTB01 control slice: bus map, register offsets, reset values, FSM states.
package xtb_01_pkg;

    localparam logic [15:0] SPI_BASE = 16'h0000;
    localparam logic [15:0] SEQ_BASE = 16'h1000;

    localparam logic [15:0] SPI_RST    = 16'h0000;
    localparam logic [15:0] SPI_START  = 16'h0001;
    localparam logic [15:0] SPI_CLKDIV = 16'h0002;
    localparam logic [15:0] SPI_DOUT_H = 16'h0008;
    localparam logic [15:0] SPI_DOUT_L = 16'h0009;
    localparam logic [15:0] SPI_DIN_H  = 16'h000A;
    localparam logic [15:0] SPI_DIN_L  = 16'h000B;

    localparam logic [15:0] SEQ_RST    = 16'h0000;
    localparam logic [15:0] SEQ_START  = 16'h0001;
    localparam logic [15:0] SEQ_CLKDIV = 16'h0002;
    localparam logic [15:0] SEQ_SIZE_H = 16'h0003;
    localparam logic [15:0] SEQ_SIZE_L = 16'h0004;
    localparam logic [15:0] SEQ_REPEAT = 16'h0007;
    localparam logic [15:0] SEQ_REP_H  = 16'h0008;
    localparam logic [15:0] SEQ_REP_L  = 16'h0009;

    localparam logic [15:0] SEQ_MEM_OFF   = 16'h0010;
    localparam int unsigned SEQ_MEM_DEPTH = 256;

    localparam logic [7:0] SPI_CLKDIV_RST = 8'd4;
    localparam logic [7:0] SEQ_CLKDIV_RST = 8'd1;

    typedef enum logic [1:0] {SpiIdle, SpiXfer, SpiEnd} spi_state_e;
    typedef enum logic {SeqIdle, SeqRun} seq_state_e;

    // Divider and repeat registers treat 0 as 1.
    function automatic logic [7:0] max1(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

endpackage

// File: rtl/xtb_01_spi_master.sv
// 16-bit mode-0 SPI master, MSB first; SCLK half-period = max(clkdiv,1) clock cycles.
module xtb_01_spi_master
    import xtb_01_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        soft_rst,
    input  logic        start,
    input  logic [7:0]  clkdiv,
    input  logic [15:0] data_out,
    input  logic        miso,
    output logic [15:0] data_in,
    output logic        done,
    output logic        csn,
    output logic        sclk,
    output logic        mosi
);

    spi_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  edge_q, edge_d;
    logic        sclk_q, sclk_d;
    logic [15:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic [7:0]  half;

    assign half = max1(clkdiv);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SpiIdle;
            cnt_q   <= '0;
            edge_q  <= '0;
            sclk_q  <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            sclk_q  <= sclk_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        sclk_d  = sclk_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        if (soft_rst) begin
            state_d = SpiIdle;
            cnt_d   = '0;
            edge_d  = '0;
            sclk_d  = 1'b0;
            tx_d    = '0;
            rx_d    = '0;
        end else begin
            unique case (state_q)
                SpiIdle: begin
                    if (start) begin
                        state_d = SpiXfer;
                        tx_d    = data_out;
                        cnt_d   = '0;
                        edge_d  = '0;
                        sclk_d  = 1'b0;
                    end
                end
                SpiXfer: begin
                    if (cnt_q == half - 8'd1) begin
                        cnt_d  = '0;
                        sclk_d = ~sclk_q;
                        edge_d = edge_q + 5'd1;
                        if (!sclk_q) begin
                            rx_d = {rx_q[14:0], miso};
                        end else begin
                            tx_d = {tx_q[14:0], 1'b0};
                            if (edge_q == 5'd31) state_d = SpiEnd;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                SpiEnd:  state_d = SpiIdle;
                default: state_d = SpiIdle;
            endcase
        end
    end

    assign csn     = (state_q == SpiIdle);
    assign done    = (state_q == SpiIdle);
    assign sclk    = sclk_q;
    assign mosi    = (state_q != SpiIdle) & tx_q[15];
    assign data_in = rx_q;

endmodule

// File: rtl/xtb_01.sv
// XTB01 control slice: bus register decode, SPI master for ADC config, pattern sequencer on DEBUG_D.
module xtb_01
    import xtb_01_pkg::*;
(
    input  logic        FCLK_IN,
    input  logic        RESET_N,
    input  logic [15:0] ADD,
    inout  wire  [7:0]  BUS_DATA,
    input  logic        RD_B,
    input  logic        WR_B,
    output logic [15:0] DEBUG_D,
    output logic        LED1,
    output logic        LED2,
    output logic        LED3,
    output logic        LED4,
    output logic        LED5,
    output logic        ADC_CSN,
    output logic        ADC_SCLK,
    output logic        ADC_SDI,
    input  logic        ADC_SD0
);

    localparam logic [15:0] SEQ_MEM_LO = SEQ_BASE + SEQ_MEM_OFF;
    localparam logic [15:0] SEQ_MEM_HI = SEQ_MEM_LO + 16'(SEQ_MEM_DEPTH - 1);

    logic        wr_b_q;
    logic        wr_stb;
    logic [7:0]  rd_data_q, rd_data_d;
    logic [7:0]  spi_div_q, dout_h_q, dout_l_q;
    logic [7:0]  seq_div_q, size_h_q, size_l_q, repeat_q, rep_h_q, rep_l_q;
    logic [7:0]  mem [SEQ_MEM_DEPTH];
    logic        mem_hit;
    logic [7:0]  mem_idx;

    logic        spi_done;
    logic [15:0] spi_din;
    logic        spi_start, spi_rst;

    seq_state_e  seq_state_q, seq_state_d;
    logic [15:0] step_q, step_d;
    logic [7:0]  cyc_q, cyc_d;
    logic [7:0]  play_q, play_d;
    logic [15:0] size, rep_start;
    logic [7:0]  seq_div, plays;
    logic        seq_start, seq_rst;
    logic [7:0]  seq_out;

    // One strobe per WR_B low pulse: the first low cycle after a high one.
    assign wr_stb    = ~WR_B & wr_b_q;
    assign mem_hit   = (ADD >= SEQ_MEM_LO) && (ADD <= SEQ_MEM_HI);
    assign mem_idx   = ADD[7:0] - SEQ_MEM_OFF[7:0];
    assign spi_start = wr_stb && (ADD == SPI_BASE + SPI_START);
    assign spi_rst   = wr_stb && (ADD == SPI_BASE + SPI_RST);
    assign seq_start = wr_stb && (ADD == SEQ_BASE + SEQ_START);
    assign seq_rst   = wr_stb && (ADD == SEQ_BASE + SEQ_RST);

    always_ff @(posedge FCLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_b_q    <= 1'b1;
            rd_data_q <= '0;
            spi_div_q <= SPI_CLKDIV_RST;
            dout_h_q  <= '0;
            dout_l_q  <= '0;
            seq_div_q <= SEQ_CLKDIV_RST;
            size_h_q  <= '0;
            size_l_q  <= '0;
            repeat_q  <= '0;
            rep_h_q   <= '0;
            rep_l_q   <= '0;
        end else begin
            wr_b_q    <= WR_B;
            rd_data_q <= rd_data_d;
            if (wr_stb) begin
                case (ADD)
                    SPI_BASE + SPI_CLKDIV: spi_div_q <= BUS_DATA;
                    SPI_BASE + SPI_DOUT_H: dout_h_q  <= BUS_DATA;
                    SPI_BASE + SPI_DOUT_L: dout_l_q  <= BUS_DATA;
                    SEQ_BASE + SEQ_CLKDIV: seq_div_q <= BUS_DATA;
                    SEQ_BASE + SEQ_SIZE_H: size_h_q  <= BUS_DATA;
                    SEQ_BASE + SEQ_SIZE_L: size_l_q  <= BUS_DATA;
                    SEQ_BASE + SEQ_REPEAT: repeat_q  <= BUS_DATA;
                    SEQ_BASE + SEQ_REP_H:  rep_h_q   <= BUS_DATA;
                    SEQ_BASE + SEQ_REP_L:  rep_l_q   <= BUS_DATA;
                    default: ;
                endcase
            end
        end
    end

    // Pattern memory has no reset; its contents are undefined until written.
    always_ff @(posedge FCLK_IN) begin
        if (wr_stb && mem_hit) mem[mem_idx] <= BUS_DATA;
    end

    always_comb begin
        rd_data_d = 8'h00;
        if (mem_hit) begin
            rd_data_d = mem[mem_idx];
        end else begin
            case (ADD)
                SPI_BASE + SPI_START:  rd_data_d = {7'b0, spi_done};
                SPI_BASE + SPI_CLKDIV: rd_data_d = spi_div_q;
                SPI_BASE + SPI_DOUT_H: rd_data_d = dout_h_q;
                SPI_BASE + SPI_DOUT_L: rd_data_d = dout_l_q;
                SPI_BASE + SPI_DIN_H:  rd_data_d = spi_din[15:8];
                SPI_BASE + SPI_DIN_L:  rd_data_d = spi_din[7:0];
                SEQ_BASE + SEQ_START:  rd_data_d = {7'b0, seq_state_q == SeqIdle};
                SEQ_BASE + SEQ_CLKDIV: rd_data_d = seq_div_q;
                SEQ_BASE + SEQ_SIZE_H: rd_data_d = size_h_q;
                SEQ_BASE + SEQ_SIZE_L: rd_data_d = size_l_q;
                SEQ_BASE + SEQ_REPEAT: rd_data_d = repeat_q;
                SEQ_BASE + SEQ_REP_H:  rd_data_d = rep_h_q;
                SEQ_BASE + SEQ_REP_L:  rd_data_d = rep_l_q;
                default: ;
            endcase
        end
    end

    assign BUS_DATA = RD_B ? 8'hzz : rd_data_q;

    xtb_01_spi_master u_spi (
        .clk      (FCLK_IN),
        .rst_n    (RESET_N),
        .soft_rst (spi_rst),
        .start    (spi_start),
        .clkdiv   (spi_div_q),
        .data_out ({dout_h_q, dout_l_q}),
        .miso     (ADC_SD0),
        .data_in  (spi_din),
        .done     (spi_done),
        .csn      (ADC_CSN),
        .sclk     (ADC_SCLK),
        .mosi     (ADC_SDI)
    );

    assign size      = {size_h_q, size_l_q};
    assign rep_start = {rep_h_q, rep_l_q};
    assign seq_div   = max1(seq_div_q);
    assign plays     = max1(repeat_q);

    always_ff @(posedge FCLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            seq_state_q <= SeqIdle;
            step_q      <= '0;
            cyc_q       <= '0;
            play_q      <= '0;
        end else begin
            seq_state_q <= seq_state_d;
            step_q      <= step_d;
            cyc_q       <= cyc_d;
            play_q      <= play_d;
        end
    end

    always_comb begin
        seq_state_d = seq_state_q;
        step_d      = step_q;
        cyc_d       = cyc_q;
        play_d      = play_q;
        if (seq_rst) begin
            seq_state_d = SeqIdle;
        end else begin
            unique case (seq_state_q)
                SeqIdle: begin
                    if (seq_start && size != 16'd0) begin
                        seq_state_d = SeqRun;
                        step_d      = '0;
                        cyc_d       = '0;
                        play_d      = '0;
                    end
                end
                SeqRun: begin
                    if (cyc_q == seq_div - 8'd1) begin
                        cyc_d = '0;
                        if (step_q == size - 16'd1) begin
                            // Replays restart at REP_START; an out-of-range start ends the run.
                            if ((play_q + 8'd1 < plays) && (rep_start < size)) begin
                                play_d = play_q + 8'd1;
                                step_d = rep_start;
                            end else begin
                                seq_state_d = SeqIdle;
                            end
                        end else begin
                            step_d = step_q + 16'd1;
                        end
                    end else begin
                        cyc_d = cyc_q + 8'd1;
                    end
                end
                default: seq_state_d = SeqIdle;
            endcase
        end
    end

    assign seq_out = (seq_state_q == SeqRun) ? mem[step_q[7:0]] : 8'h00;

    assign DEBUG_D = {8'h00, seq_out};
    assign LED1    = ~spi_done;
    assign LED2    = (seq_state_q == SeqRun);
    assign LED3    = 1'b0;
    assign LED4    = 1'b0;
    assign LED5    = 1'b0;

endmodule

// File: tb/tb_xtb_01.sv
// Self-checking bench for xtb_01: register table, SPI loopback, sequencer scoreboard, aborts.
module tb_xtb_01;

    logic        FCLK_IN = 1'b0;
    logic        RESET_N = 1'b0;
    logic [15:0] ADD = 16'h0000;
    wire  [7:0]  BUS_DATA;
    logic        RD_B = 1'b1;
    logic        WR_B = 1'b1;
    logic [15:0] DEBUG_D;
    logic        LED1, LED2, LED3, LED4, LED5;
    logic        ADC_CSN, ADC_SCLK, ADC_SDI;
    logic        ADC_SD0 = 1'b1;

    logic        tb_oe = 1'b0;
    logic [7:0]  tb_dout = 8'h00;

    assign BUS_DATA = tb_oe ? tb_dout : 8'hzz;

    xtb_01 dut (
        .FCLK_IN  (FCLK_IN),
        .RESET_N  (RESET_N),
        .ADD      (ADD),
        .BUS_DATA (BUS_DATA),
        .RD_B     (RD_B),
        .WR_B     (WR_B),
        .DEBUG_D  (DEBUG_D),
        .LED1     (LED1),
        .LED2     (LED2),
        .LED3     (LED3),
        .LED4     (LED4),
        .LED5     (LED5),
        .ADC_CSN  (ADC_CSN),
        .ADC_SCLK (ADC_SCLK),
        .ADC_SDI  (ADC_SDI),
        .ADC_SD0  (ADC_SD0)
    );

    always #10 FCLK_IN = ~FCLK_IN;

    // ADC model: MISO held 1 while deselected, toggled on every SCLK fall.
    always @(negedge ADC_SCLK) if (!ADC_CSN) ADC_SD0 <= ~ADC_SD0;
    always @(posedge ADC_CSN) ADC_SD0 <= 1'b1;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        string       name;
    } vec_t;

    vec_t        vecs [16];
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  tb_mem [256];
    logic [7:0]  exp_q [$];
    logic        bit_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge FCLK_IN);
        ADD = a; tb_dout = d; tb_oe = 1'b1; WR_B = 1'b0;
        @(negedge FCLK_IN);
        WR_B = 1'b1; tb_oe = 1'b0;
        if (a >= 16'h1010 && a <= 16'h110F) tb_mem[a - 16'h1010] = d;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge FCLK_IN);
        ADD = a; RD_B = 1'b0;
        @(negedge FCLK_IN);
        d = BUS_DATA; RD_B = 1'b1;
    endtask

    task automatic read_check(input string name, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic seq_config(input int div, input int size, input int rep, input int rs);
        bus_write(16'h1000, 8'h00);
        bus_write(16'h1002, 8'(div));
        bus_write(16'h1003, 8'(size >> 8));
        bus_write(16'h1004, 8'(size));
        bus_write(16'h1007, 8'(rep));
        bus_write(16'h1008, 8'(rs >> 8));
        bus_write(16'h1009, 8'(rs));
    endtask

    // Expected DEBUG_D byte for every cycle of a run, derived from the register semantics.
    task automatic build_exp(input int div, input int size, input int rep, input int rs);
        int d, p;
        d = (div == 0) ? 1 : div;
        p = (rep == 0) ? 1 : rep;
        exp_q.delete();
        for (int k = 0; k < p; k++) begin
            int first;
            first = (k == 0) ? 0 : rs;
            if (k > 0 && rs >= size) break;
            for (int s = first; s < size; s++)
                for (int c = 0; c < d; c++) exp_q.push_back(tb_mem[s % 256]);
        end
    endtask

    task automatic seq_play(input string name);
        int cnt, len;
        logic [7:0] e;
        len = exp_q.size();
        cnt = 0;
        bus_write(16'h1001, 8'h01);
        for (int c = 0; c < 5000 && LED2 == 1'b1; c++) begin
            if (exp_q.size() == 0) break;
            e = exp_q.pop_front();
            check({name, " step"}, DEBUG_D, {8'h00, e});
            cnt++;
            @(negedge FCLK_IN);
        end
        check({name, " busy cycles"}, cnt, len);
        check({name, " idle"}, LED2, 1'b0);
        check({name, " debug idle"}, DEBUG_D, 16'h0000);
        read_check({name, " done"}, 16'h1001, 8'h01);
    endtask

    task automatic spi_start_pulse();
        @(negedge FCLK_IN);
        ADD = 16'h0001; tb_dout = 8'h01; tb_oe = 1'b1; WR_B = 1'b0;
        @(negedge FCLK_IN);
        WR_B = 1'b1; tb_oe = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int rises, low_cycles;
        logic prev;
        logic [15:0] word;

        vecs[0]  = '{1'b0, 16'h0001, 8'h01, "spi done after reset"};
        vecs[1]  = '{1'b0, 16'h1001, 8'h01, "seq done after reset"};
        vecs[2]  = '{1'b0, 16'h0002, 8'h04, "spi clkdiv default"};
        vecs[3]  = '{1'b0, 16'h1002, 8'h01, "seq clkdiv default"};
        vecs[4]  = '{1'b0, 16'h0003, 8'h00, "unmapped spi+3"};
        vecs[5]  = '{1'b0, 16'h2000, 8'h00, "unmapped 0x2000"};
        vecs[6]  = '{1'b0, 16'h000A, 8'h00, "spi data_in reset"};
        vecs[7]  = '{1'b1, 16'h0002, 8'h02, ""};
        vecs[8]  = '{1'b0, 16'h0002, 8'h02, "spi clkdiv rw"};
        vecs[9]  = '{1'b1, 16'h1003, 8'h12, ""};
        vecs[10] = '{1'b0, 16'h1003, 8'h12, "seq size_h rw"};
        vecs[11] = '{1'b1, 16'h1007, 8'h03, ""};
        vecs[12] = '{1'b0, 16'h1007, 8'h03, "seq repeat rw"};
        vecs[13] = '{1'b1, 16'h0003, 8'h77, ""};
        vecs[14] = '{1'b0, 16'h0003, 8'h00, "unmapped write ignored"};
        vecs[15] = '{1'b0, 16'h000A, 8'h00, "data_in still zero"};

        repeat (3) @(negedge FCLK_IN);
        RESET_N = 1'b1;
        @(negedge FCLK_IN);
        check("reset csn", ADC_CSN, 1'b1);
        check("reset sclk", ADC_SCLK, 1'b0);
        check("reset sdi", ADC_SDI, 1'b0);
        check("reset debug", DEBUG_D, 16'h0000);
        check("reset leds", {LED1, LED2, LED3, LED4, LED5}, 5'b00000);
        ADD = 16'h0001;
        @(negedge FCLK_IN);
        check("bus released when RD_B=1", (BUS_DATA === 8'h01), 1'b0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
            else read_check(vecs[i].name, vecs[i].addr, vecs[i].data);
        end

        // Memory readback at both ends of the window.
        for (int i = 0; i < 256; i++) bus_write(16'h1010 + 16'(i), 8'h00);
        bus_write(16'h1010, 8'h5A);
        bus_write(16'h110F, 8'hA5);
        read_check("mem[0]", 16'h1010, 8'h5A);
        read_check("mem[255]", 16'h110F, 8'hA5);
        read_check("mem[1] unchanged", 16'h1011, 8'h00);
        read_check("mem[254] unchanged", 16'h110E, 8'h00);
        read_check("mem[128] unchanged", 16'h1090, 8'h00);
        read_check("past mem window", 16'h1110, 8'h00);
        read_check("below mem window", 16'h100F, 8'h00);
        bus_write(16'h1010, 8'h00);
        bus_write(16'h110F, 8'h00);

        // SPI loopback.
        bus_write(16'h0002, 8'h03);
        bus_write(16'h0008, 8'h80);
        bus_write(16'h0009, 8'hFF);
        word = 16'h80FF;
        for (int i = 15; i >= 0; i--) bit_q.push_back(word[i]);
        spi_start_pulse();
        check("spi csn low after start", ADC_CSN, 1'b0);
        check("spi led1 busy", LED1, 1'b1);
        check("spi first sdi", ADC_SDI, 1'b1);
        rises = 0;
        low_cycles = 1;
        prev = ADC_SCLK;
        for (int c = 0; c < 2000 && !ADC_CSN; c++) begin
            @(negedge FCLK_IN);
            if (!ADC_CSN) low_cycles++;
            if (ADC_SCLK && !prev) begin
                rises++;
                if (bit_q.size() > 0) check("spi sdi bit", ADC_SDI, bit_q.pop_front());
            end
            prev = ADC_SCLK;
        end
        check("spi sclk rises", rises, 16);
        check("spi csn low cycles", low_cycles, 32 * 3 + 1);
        check("spi csn idle", ADC_CSN, 1'b1);
        check("spi sclk idle", ADC_SCLK, 1'b0);
        check("spi led1 idle", LED1, 1'b0);
        read_check("spi data_in high", 16'h000A, 8'hAA);
        read_check("spi data_in low", 16'h000B, 8'hAA);
        read_check("spi done", 16'h0001, 8'h01);

        // SPI soft reset mid-transfer.
        spi_start_pulse();
        repeat (20) @(negedge FCLK_IN);
        check("spi busy before abort", ADC_CSN, 1'b0);
        bus_write(16'h0000, 8'h00);
        check("spi abort csn", ADC_CSN, 1'b1);
        check("spi abort sclk", ADC_SCLK, 1'b0);
        check("spi abort led1", LED1, 1'b0);
        read_check("spi abort data_in high", 16'h000A, 8'h00);
        read_check("spi abort data_in low", 16'h000B, 8'h00);
        read_check("spi abort done", 16'h0001, 8'h01);

        // Sequencer single play.
        seq_config(8, 16'h0080, 1, 0);
        bus_write(16'h1011, 8'h01);
        build_exp(8, 16'h0080, 1, 0);
        seq_play("seq single");

        // Sequencer with repeat.
        for (int i = 0; i < 16; i++) bus_write(16'h1010 + 16'(i), 8'(i + 1));
        seq_config(1, 16, 2, 1);
        build_exp(1, 16, 2, 1);
        seq_play("seq repeat");

        // REP_START beyond SIZE: one play only.
        seq_config(1, 4, 3, 4);
        build_exp(1, 4, 3, 4);
        seq_play("seq rep_start>=size");

        // CLKDIV 0 behaves as 1, two plays from step 2.
        seq_config(0, 5, 2, 2);
        build_exp(0, 5, 2, 2);
        seq_play("seq clkdiv0");

        // SIZE 0: nothing runs.
        seq_config(1, 0, 1, 0);
        bus_write(16'h1001, 8'h01);
        check("seq size0 led2", LED2, 1'b0);
        check("seq size0 debug", DEBUG_D, 16'h0000);
        read_check("seq size0 done", 16'h1001, 8'h01);

        // Sequencer soft reset mid-run.
        seq_config(1, 16, 1, 0);
        bus_write(16'h1001, 8'h01);
        repeat (5) @(negedge FCLK_IN);
        check("seq running before abort", LED2, 1'b1);
        check("seq mid-run output", DEBUG_D, {8'h00, tb_mem[5]});
        bus_write(16'h1000, 8'h00);
        check("seq abort debug", DEBUG_D, 16'h0000);
        check("seq abort led2", LED2, 1'b0);
        read_check("seq abort done", 16'h1001, 8'h01);
        read_check("seq abort keeps mem", 16'h1013, 8'h04);
        read_check("seq abort keeps size", 16'h1004, 8'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
